nios_sd_loader_pio_in: RTL and testbench



---
 rtl/nios_sd_loader_pio_in.sv | 117 +++++++++++
 tb/tb_nios_sd_loader_pio_in.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sd_loader_pio_in.sv
// Avalon-MM input PIO: per-bit synchroniser, glitch filter and edge capture,
// with a maskable level- or edge-driven interrupt to the Nios.
module nios_sd_loader_pio_in #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int EDGE_TYPE     = 0,
    parameter int IRQ_MODE      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);
    localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            logic [WIDTH-1:0] filt_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) filt_q <= '0;
                else          filt_q <= s;
            end
            assign filt = filt_q;
        end else begin : g_filter
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          filt_q;
                // A bit only follows s after FILTER_CYCLES consecutive mismatching cycles.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt    <= '0;
                        filt_q <= 1'b0;
                    end else if (s[b] != filt_q) begin
                        if (cnt == CW'(FILTER_CYCLES - 1)) begin
                            filt_q <= s[b];
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                assign filt[b] = filt_q;
            end
        end
    endgenerate

    assign rise     = filt & ~filt_d;
    assign fall     = ~filt & filt_d;
    assign edge_hit = (EDGE_TYPE == 0) ? rise :
                      (EDGE_TYPE == 1) ? fall : (rise | fall);

    assign wr       = chipselect & ~write_n;
    assign clr_mask = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = filt;
            2'd2:    rd_next[WIDTH-1:0] = irqmask;
            2'd3:    rd_next[WIDTH-1:0] = edgecapture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d      <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            filt_d <= filt;
            if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
            // New edge is OR-ed after the clear so a same-cycle set wins.
            edgecapture <= (edgecapture & ~clr_mask) | edge_hit;
            readdata    <= rd_next;
        end
    end

    assign irq = (IRQ_MODE == 1) ? |(edgecapture & irqmask) : |(filt & irqmask);

endmodule

// File: tb/tb_nios_sd_loader_pio_in.sv
// Bench for nios_sd_loader_pio_in: four differently configured instances,
// directed scenarios plus randomized traffic against an input-history model.
module tb_nios_sd_loader_pio_in;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs   [4];
    logic [7:0]  inp  [4];
    logic [31:0] rd   [4];
    logic        irq  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: filter 3, rising, edge irq   1: filter 3, any edge, edge irq
    // 2: filter 3, rising, level irq  3: sync 3, no filter, falling, edge irq
    nios_sd_loader_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(3), .EDGE_TYPE(0), .IRQ_MODE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .readdata(rd[0]), .in_port(inp[0]), .irq(irq[0]));
    nios_sd_loader_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(3), .EDGE_TYPE(2), .IRQ_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .readdata(rd[1]), .in_port(inp[1]), .irq(irq[1]));
    nios_sd_loader_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(3), .EDGE_TYPE(0), .IRQ_MODE(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .readdata(rd[2]), .in_port(inp[2]), .irq(irq[2]));
    nios_sd_loader_pio_in #(.WIDTH(8), .SYNC_STAGES(3), .FILTER_CYCLES(0), .EDGE_TYPE(1), .IRQ_MODE(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]), .write_n(write_n),
        .writedata(writedata), .readdata(rd[3]), .in_port(inp[3]), .irq(irq[3]));

    function automatic int p_sync(int i);  return (i == 3) ? 3 : 2; endfunction
    function automatic int p_win(int i);   return (i == 3) ? 1 : 3; endfunction
    function automatic int p_edge(int i);  return (i == 1) ? 2 : (i == 3) ? 1 : 0; endfunction
    function automatic int p_mode(int i);  return (i == 2) ? 0 : 1; endfunction

    // Reference model: the filtered value flips once the raw input, seen
    // through the synchroniser delay, has disagreed with it for a full window.
    logic [7:0]  m_hist [4][8];
    logic [7:0]  m_filt [4];
    logic [7:0]  m_prev [4];
    logic [7:0]  m_ec   [4];
    logic [7:0]  m_mask [4];
    logic [31:0] m_rd   [4];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 8; k++) m_hist[i][k] <= 8'h00;
                m_filt[i] <= 8'h00; m_prev[i] <= 8'h00; m_ec[i] <= 8'h00;
                m_mask[i] <= 8'h00; m_rd[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                automatic logic [7:0] nf = m_filt[i];
                automatic logic [7:0] edg;
                automatic logic [7:0] clr;
                automatic bit         wr_i = cs[i] && !write_n;
                for (int b = 0; b < 8; b++) begin
                    automatic bit flip = 1'b1;
                    for (int j = 0; j < p_win(i); j++)
                        if (m_hist[i][p_sync(i) - 1 + j][b] == m_filt[i][b]) flip = 1'b0;
                    if (flip) nf[b] = ~m_filt[i][b];
                end
                case (p_edge(i))
                    0:       edg = m_filt[i] & ~m_prev[i];
                    1:       edg = ~m_filt[i] & m_prev[i];
                    default: edg = m_filt[i] ^ m_prev[i];
                endcase
                clr = (wr_i && address == 2'd3) ? writedata[7:0] : 8'h00;
                m_ec[i] <= (m_ec[i] & ~clr) | edg;
                if (wr_i && address == 2'd2) m_mask[i] <= writedata[7:0];
                case (address)
                    2'd0:    m_rd[i] <= {24'h0, m_filt[i]};
                    2'd2:    m_rd[i] <= {24'h0, m_mask[i]};
                    2'd3:    m_rd[i] <= {24'h0, m_ec[i]};
                    default: m_rd[i] <= 32'h0;
                endcase
                m_filt[i] <= nf;
                m_prev[i] <= m_filt[i];
                for (int k = 7; k > 0; k--) m_hist[i][k] <= m_hist[i][k-1];
                m_hist[i][0] <= inp[i];
            end
        end
    end

    function automatic logic m_irq(int i);
        return (p_mode(i) == 1) ? |(m_ec[i] & m_mask[i]) : |(m_filt[i] & m_mask[i]);
    endfunction

    task automatic bus_write(int i, logic [1:0] a, logic [31:0] d);
        @(negedge clk);
        cs[i] = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        cs[i] = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(logic [1:0] a);
        @(negedge clk);
        address = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = 32'h0;
        for (int i = 0; i < 4; i++) begin cs[i] = 1'b0; inp[i] = 8'h00; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== 32'h0 || irq[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read inst%0d addr%0d: rd=%h irq=%b, required rd=0 irq=0", i, a, rd[i], irq[i]);
                end
            end
        end
    endtask

    task automatic test_edge_irq;
        bus_write(0, 2'd2, 32'h01);
        @(negedge clk);
        address = 2'd0; inp[0] = 8'h01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd[0] !== 32'h0 || irq[0] !== 1'b0) begin
            errors++;
            $display("FAIL early_data: rd=%h irq=%b, required rd=0 irq=0", rd[0], irq[0]);
        end
        @(negedge clk);
        checks++;
        if (rd[0] !== 32'h01 || irq[0] !== 1'b1) begin
            errors++;
            $display("FAIL data_rise: rd=%h irq=%b, required rd=1 irq=1", rd[0], irq[0]);
        end
        bus_read(2'd3);
        checks++;
        if (rd[0] !== 32'h01) begin
            errors++;
            $display("FAIL edgecap_rise: rd=%h, required 1", rd[0]);
        end
        bus_write(0, 2'd3, 32'h01);
        @(negedge clk);
        checks++;
        if (irq[0] !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b, required 0", irq[0]);
        end
        bus_read(2'd3);
        checks++;
        if (rd[0] !== 32'h0) begin
            errors++;
            $display("FAIL edgecap_clear: rd=%h, required 0", rd[0]);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        inp[0] = 8'h81;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        inp[0] = 8'h01;
        repeat (12) @(posedge clk);
        bus_read(2'd0);
        checks++;
        if (rd[0] !== 32'h01) begin
            errors++;
            $display("FAIL glitch_data: rd=%h, required 01", rd[0]);
        end
        bus_read(2'd3);
        checks++;
        if (rd[0] !== 32'h0) begin
            errors++;
            $display("FAIL glitch_edgecap: rd=%h, required 0", rd[0]);
        end
    endtask

    task automatic test_any_edge;
        logic [7:0] lvl [2];
        lvl[0] = 8'h08; lvl[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            inp[1] = lvl[k];
            repeat (10) @(posedge clk);
            bus_read(2'd3);
            checks++;
            if (rd[1] !== 32'h08) begin
                errors++;
                $display("FAIL any_edge_%0d: rd=%h, required 08", k, rd[1]);
            end
            bus_write(1, 2'd3, 32'h08);
        end
        // The clear lands on exactly the edge where the new capture happens.
        @(negedge clk);
        inp[1] = 8'h08;
        repeat (5) @(posedge clk);
        bus_write(1, 2'd3, 32'h08);
        bus_read(2'd3);
        checks++;
        if (rd[1] !== 32'h08) begin
            errors++;
            $display("FAIL set_beats_clear: rd=%h, required 08", rd[1]);
        end
    endtask

    task automatic test_level_irq;
        bus_write(2, 2'd2, 32'h04);
        @(negedge clk);
        inp[2] = 8'h04;
        repeat (8) @(negedge clk);
        checks++;
        if (irq[2] !== 1'b1) begin
            errors++;
            $display("FAIL level_irq_high: irq=%b, required 1", irq[2]);
        end
        bus_write(2, 2'd2, 32'h00);
        @(negedge clk);
        checks++;
        if (irq[2] !== 1'b0) begin
            errors++;
            $display("FAIL level_irq_masked: irq=%b, required 0", irq[2]);
        end
    endtask

    task automatic test_reset_mid_filter;
        @(negedge clk);
        for (int i = 0; i < 4; i++) inp[i] = 8'hFF;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 32'h0 || irq[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset inst%0d: rd=%h irq=%b, required 0", i, rd[i], irq[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        bus_read(2'd3);
        checks++;
        if (rd[0] !== 32'hFF) begin
            errors++;
            $display("FAIL post_reset_edges: rd=%h, required FF", rd[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== m_rd[i]) begin
                errors++;
                $display("FAIL post_reset_model inst%0d: rd=%h, required %h", i, rd[i], m_rd[i]);
            end
        end
        bus_read(2'd2);
        checks++;
        if (rd[0] !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_mask: rd=%h, required 0", rd[0]);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== m_rd[i] || irq[i] !== m_irq(i)) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d: rd=%h irq=%b, required rd=%h irq=%b",
                             n, i, rd[i], irq[i], m_rd[i], m_irq(i));
                end
            end
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            write_n = 1'b1;
            for (int i = 0; i < 4; i++) cs[i] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                write_n = 1'b0;
                cs[$urandom_range(0, 3)] = 1'b1;
            end
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 4) == 0) inp[i] = 8'($urandom);
        end
        @(negedge clk);
        write_n = 1'b1;
        for (int i = 0; i < 4; i++) cs[i] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_irq();
        test_glitch();
        test_any_edge();
        test_level_irq();
        test_reset_mid_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
